// File: rtl/axi_cmd_master.sv
// axi_cmd_master: single-outstanding AXI4 initiator. It turns a command plus a
// write/read payload stream into one INCR burst at a time, and reports each
// completion with a one-cycle done pulse and an error flag.
module axi_cmd_master #(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    localparam int STRB_W = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command interface
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ID_W_WIDTH-1:0] cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    // write payload stream
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [STRB_W-1:0]     wstrb_in,
    input  logic                  wdata_valid_in,
    output logic                  wdata_ready_out,
    // read payload stream
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  rdata_valid,
    output logic                  rdata_last,
    input  logic                  rdata_ready,
    // completion
    output logic                  done_valid,
    output logic                  done_write,
    output logic                  done_err,
    // AXI write address
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [ID_W_WIDTH-1:0] aw_id,
    output logic [ADDR_WIDTH-1:0] aw_addr,
    output logic [7:0]            aw_len,
    output logic [2:0]            aw_size,
    output logic [1:0]            aw_burst,
    // AXI write data
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [STRB_W-1:0]     w_strb,
    // AXI write response
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ID_W_WIDTH-1:0] b_id,
    input  logic [1:0]            b_resp,
    // AXI read address
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ID_R_WIDTH-1:0] ar_id,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    // AXI read data
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic                  r_last,
    input  logic [ID_R_WIDTH-1:0] r_id,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));
    localparam logic [1:0] AXI_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            beat_cnt;
    logic                  err_q;
    logic [ID_W_WIDTH-1:0] id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  write_q;

    logic                  beat_is_last;
    logic                  w_fire;
    logic                  r_fire;
    logic                  r_beat_err;

    assign beat_is_last = (beat_cnt == len_q);
    assign w_fire       = wdata_valid_in && w_ready;
    assign r_fire       = r_valid && rdata_ready;
    // A read beat is bad if the responder flags it, tags it with a foreign ID,
    // or places r_last somewhere other than the beat we count as last.
    assign r_beat_err   = (r_resp != 2'b00) || (r_id != id_q[ID_R_WIDTH-1:0]) ||
                          (r_last != beat_is_last);

    assign aw_id    = id_q;
    assign aw_addr  = addr_q;
    assign aw_len   = len_q;
    assign aw_size  = AXI_SIZE;
    assign aw_burst = AXI_INCR;
    assign ar_id    = id_q[ID_R_WIDTH-1:0];
    assign ar_addr  = addr_q;
    assign ar_len   = len_q;
    assign ar_size  = AXI_SIZE;
    assign ar_burst = AXI_INCR;
    assign w_data   = wdata_in;
    assign w_strb   = wstrb_in;
    assign rdata_out = r_data;

    // State register; reset aborts any burst in flight straight back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and all handshake outputs, gated by the current state.
    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        aw_valid        = 1'b0;
        ar_valid        = 1'b0;
        w_valid         = 1'b0;
        w_last          = 1'b0;
        wdata_ready_out = 1'b0;
        b_ready         = 1'b0;
        r_ready         = 1'b0;
        rdata_valid     = 1'b0;
        rdata_last      = 1'b0;
        done_valid      = 1'b0;
        done_write      = 1'b0;
        done_err        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                aw_valid = 1'b1;
                if (aw_ready) begin
                    state_nxt = WDATA;
                end
            end
            WDATA: begin
                w_valid         = wdata_valid_in;
                wdata_ready_out = w_ready;
                w_last          = beat_is_last;
                if (w_fire && beat_is_last) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_nxt = DONE;
                end
            end
            RADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                rdata_valid = r_valid;
                r_ready     = rdata_ready;
                rdata_last  = beat_is_last;
                if (r_fire && beat_is_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                done_write = write_q;
                done_err   = err_q;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beat counter and sticky error flag; both restart on each accepted command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        beat_cnt <= 8'd0;
                        err_q    <= 1'b0;
                    end
                end
                WDATA: begin
                    if (w_fire) begin
                        beat_cnt <= beat_is_last ? 8'd0 : beat_cnt + 8'd1;
                    end
                end
                WRESP: begin
                    if (b_valid) begin
                        err_q <= (b_resp != 2'b00) || (b_id != id_q);
                    end
                end
                RDATA: begin
                    if (r_fire) begin
                        beat_cnt <= beat_is_last ? 8'd0 : beat_cnt + 8'd1;
                        err_q    <= err_q || r_beat_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Command fields are captured on acceptance and held for the whole burst.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            id_q    <= cmd_id;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            write_q <= cmd_write;
        end
    end

endmodule

// File: tb/tb_axi_cmd_master.sv
// tb_axi_cmd_master: drives axi_cmd_master with a table of directed commands,
// a mid-burst reset, and randomized commands with random handshake timing,
// while playing both the payload source/sink and a memory-backed AXI responder.
module tb_axi_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wdata_in;
    logic [3:0]  wstrb_in;
    logic        wdata_valid_in, wdata_ready_out;
    logic [31:0] rdata_out;
    logic        rdata_valid, rdata_last, rdata_ready;
    logic        done_valid, done_write, done_err;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_id;
    logic [15:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_id;
    logic [15:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready, r_last;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int n_cmp;
    int n_bad;

    // responder storage and the bench's own expectation of memory contents
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        logic        wr;
        logic [3:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        int          fault;
        logic [31:0] dbase;
        logic        exp_err;
    } vec_t;

    vec_t tbl [7];

    axi_cmd_master dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in),
        .wdata_valid_in(wdata_valid_in), .wdata_ready_out(wdata_ready_out),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
        .rdata_ready(rdata_ready),
        .done_valid(done_valid), .done_write(done_write), .done_err(done_err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .r_id(r_id),
        .r_data(r_data), .r_resp(r_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        return m;
    endfunction

    // Responder misbehaviour per read beat: 3 = r_last only on beat 1,
    // 4 = SLVERR on the final beat, 5 = wrong r_id on beat 0.
    function automatic logic f_last(input int fault, input int i, input int len);
        return (fault == 3) ? (i == 1) : (i == len);
    endfunction

    function automatic logic [1:0] f_rresp(input int fault, input int i, input int len);
        return (fault == 4 && i == len) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [3:0] f_rid(input int fault, input int i, input logic [3:0] id);
        return (fault == 5 && i == 0) ? (id ^ 4'h1) : id;
    endfunction

    // Expected completion error: writes fail on bad b_resp (1) or b_id (2);
    // reads fail if any of the len+1 beats is flagged, mis-tagged or mis-lasted.
    function automatic logic model_err(input logic wr, input int fault, input int len);
        if (wr) return (fault == 1) || (fault == 2);
        for (int i = 0; i <= len; i++) begin
            if (f_last(fault, i, len) != (i == len)) return 1'b1;
            if (f_rresp(fault, i, len) != 2'b00) return 1'b1;
        end
        return (fault == 5);
    endfunction

    task automatic clear_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0;
        wdata_in = 0; wstrb_in = 0; wdata_valid_in = 0; rdata_ready = 0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_id = 0; b_resp = 0;
        ar_ready = 0; r_valid = 0; r_last = 0; r_id = 0; r_data = 0; r_resp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        chk({tag, " aw_valid"}, aw_valid, 0);
        chk({tag, " ar_valid"}, ar_valid, 0);
        chk({tag, " w_valid"}, w_valid, 0);
        chk({tag, " done_valid"}, done_valid, 0);
        chk({tag, " done_err"}, done_err, 0);
        chk({tag, " done_write"}, done_write, 0);
        chk({tag, " wdata_ready_out"}, wdata_ready_out, 0);
        chk({tag, " r_ready"}, r_ready, 0);
        chk({tag, " b_ready"}, b_ready, 0);
        chk({tag, " rdata_valid"}, rdata_valid, 0);
    endtask

    // One full transaction with random handshake timing on every channel.
    task automatic run_txn(input logic wr, input logic [3:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input int fault, input logic [31:0] dbase,
                           input logic exp_err, input string tag);
        logic [31:0] wq[$];
        logic [3:0]  sq[$];
        logic [31:0] wgot_d[$];
        logic [3:0]  wgot_s[$];
        logic        wgot_l[$];
        logic [31:0] rgot_d[$];
        logic        rgot_l[$];
        logic [7:0]  base;
        int          src_i, w_got, r_idx, aw_hs, ar_hs, done_cnt, cyc;
        bit          ar_ok, b_given, finished;
        logic        dw, de;
        base = addr[9:2];
        src_i = 0; w_got = 0; r_idx = 0; aw_hs = 0; ar_hs = 0; done_cnt = 0; cyc = 0;
        ar_ok = 0; b_given = 0; finished = 0; dw = 0; de = 0;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] d;
            logic [3:0]  s;
            d = (dbase != 0) ? dbase + 32'(i) : $urandom;
            s = (dbase != 0) ? 4'hF : 4'($urandom);
            wq.push_back(d);
            sq.push_back(s);
            if (wr) ref_mem[8'(base + i)] = merge(ref_mem[8'(base + i)], d, s);
        end

        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
        #1;
        chk({tag, " cmd_ready idle"}, cmd_ready, 1);

        while (!finished && cyc < 400) begin
            @(negedge clk);
            cmd_valid   = 0;
            aw_ready    = 1'($urandom_range(0, 1));
            ar_ready    = 1'($urandom_range(0, 1));
            w_ready     = 1'($urandom_range(0, 1));
            rdata_ready = 1'($urandom_range(0, 1));
            wdata_valid_in = wr && (src_i <= int'(len)) && ($urandom_range(0, 1) == 1);
            wdata_in = (src_i <= int'(len)) ? wq[src_i] : 32'h0;
            wstrb_in = (src_i <= int'(len)) ? sq[src_i] : 4'h0;
            b_valid  = wr && (w_got == int'(len) + 1) && !b_given && ($urandom_range(0, 1) == 1);
            b_id     = (fault == 2) ? (id ^ 4'h1) : id;
            b_resp   = (fault == 1) ? 2'b10 : 2'b00;
            r_valid  = !wr && ar_ok && (r_idx <= int'(len)) && ($urandom_range(0, 1) == 1);
            r_data   = mem[8'(base + r_idx)];
            r_last   = f_last(fault, r_idx, int'(len));
            r_resp   = f_rresp(fault, r_idx, int'(len));
            r_id     = f_rid(fault, r_idx, id);
            #1;
            if (cyc == 0) begin
                chk({tag, " addr valid 1 cycle after accept"}, wr ? aw_valid : ar_valid, 1);
                chk({tag, " cmd_ready busy"}, cmd_ready, 0);
            end
            if (done_cnt > 0 && !done_valid) begin
                chk({tag, " cmd_ready after done"}, cmd_ready, 1);
                finished = 1;
            end
            if (aw_valid && aw_ready) begin
                aw_hs++;
                if (aw_hs == 1)
                    chk({tag, " aw fields"}, {aw_addr, aw_id, aw_len, aw_size, aw_burst},
                        {addr, id, len, 3'd2, 2'b01});
            end
            if (ar_valid && ar_ready) begin
                ar_hs++;
                ar_ok = 1;
                if (ar_hs == 1)
                    chk({tag, " ar fields"}, {ar_addr, ar_id, ar_len, ar_size, ar_burst},
                        {addr, id, len, 3'd2, 2'b01});
            end
            if (wdata_valid_in && wdata_ready_out) src_i++;
            if (w_valid && w_ready) begin
                wgot_d.push_back(w_data);
                wgot_s.push_back(w_strb);
                wgot_l.push_back(w_last);
                mem[8'(base + w_got)] = merge(mem[8'(base + w_got)], w_data, w_strb);
                w_got++;
            end
            if (b_valid && b_ready) b_given = 1;
            if (r_valid && r_ready) r_idx++;
            if (rdata_valid && rdata_ready) begin
                rgot_d.push_back(rdata_out);
                rgot_l.push_back(rdata_last);
            end
            if (done_valid) begin
                done_cnt++;
                dw = done_write;
                de = done_err;
            end
            cyc++;
        end

        chk({tag, " completed within budget"}, finished, 1);
        chk({tag, " aw handshakes"}, aw_hs, wr ? 1 : 0);
        chk({tag, " ar handshakes"}, ar_hs, wr ? 0 : 1);
        chk({tag, " w beats"}, wgot_d.size(), wr ? int'(len) + 1 : 0);
        chk({tag, " rdata beats"}, rgot_d.size(), wr ? 0 : int'(len) + 1);
        for (int i = 0; i < wgot_d.size() && i <= int'(len); i++) begin
            chk($sformatf("%s w beat%0d data/strb/last", tag, i),
                {wgot_d[i], wgot_s[i], wgot_l[i]}, {wq[i], sq[i], 1'(i == int'(len))});
        end
        for (int i = 0; i < rgot_d.size() && i <= int'(len); i++) begin
            chk($sformatf("%s rdata beat%0d data/last", tag, i),
                {rgot_d[i], rgot_l[i]}, {ref_mem[8'(base + i)], 1'(i == int'(len))});
        end
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " done_write"}, dw, wr);
        chk({tag, " done_err"}, de, exp_err);

        clear_inputs();
        if (!finished) do_reset();
    endtask

    initial begin
        int dcnt;
        n_cmp = 0;
        n_bad = 0;
        clear_inputs();
        rst_n = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
            ref_mem[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0101_0101);
        end

        //          wr  id    addr      len fault dbase      exp_err
        tbl[0] = '{1'b1, 4'd5, 16'h0010, 8'd3, 0, 32'h0000_00A0, 1'b0};
        tbl[1] = '{1'b0, 4'd5, 16'h0010, 8'd3, 0, 32'h0,         1'b0};
        tbl[2] = '{1'b1, 4'd3, 16'h0040, 8'd1, 1, 32'h0,         1'b1};
        tbl[3] = '{1'b1, 4'd7, 16'h0048, 8'd2, 2, 32'h0,         1'b1};
        tbl[4] = '{1'b0, 4'd2, 16'h0010, 8'd3, 3, 32'h0,         1'b1};
        tbl[5] = '{1'b0, 4'd4, 16'h0040, 8'd1, 4, 32'h0,         1'b1};
        tbl[6] = '{1'b0, 4'd6, 16'h0044, 8'd0, 5, 32'h0,         1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_idle("reset");
        rst_n = 1;

        for (int k = 0; k < 7; k++) begin
            run_txn(tbl[k].wr, tbl[k].id, tbl[k].addr, tbl[k].len, tbl[k].fault,
                    tbl[k].dbase, tbl[k].exp_err, $sformatf("vec%0d", k));
        end

        // reset while beat 2 of a 4-beat write is on the bus
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_id = 4'd9; cmd_addr = 16'h0320; cmd_len = 8'd3;
        @(negedge clk);
        cmd_valid = 0; aw_ready = 1;
        #1;
        chk("abort aw_valid", aw_valid, 1);
        @(negedge clk);
        aw_ready = 0; wdata_valid_in = 1; w_ready = 1; wdata_in = 32'hB0; wstrb_in = 4'hF;
        #1;
        chk("abort beat0 w_valid", w_valid, 1);
        @(negedge clk);
        wdata_in = 32'hB1;
        @(negedge clk);
        wdata_in = 32'hB2;
        rst_n = 0;
        #1;
        chk("abort beat2 w_last", w_last, 0);
        @(negedge clk);
        rst_n = 1;
        rdata_ready = 1; r_valid = 1; b_valid = 1;
        #1;
        check_idle("abort");
        clear_inputs();
        dcnt = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done_valid) dcnt++;
        end
        chk("abort no done pulse", dcnt, 0);

        // single-beat bursts after the abort
        run_txn(1'b1, 4'd1, 16'h0060, 8'd0, 0, 32'h0000_0011, 1'b0, "len0 wr");
        run_txn(1'b0, 4'd1, 16'h0060, 8'd0, 0, 32'h0, 1'b0, "len0 rd");

        for (int k = 0; k < 40; k++) begin
            logic       wr;
            logic [7:0] len;
            int         fault;
            wr    = 1'($urandom_range(0, 1));
            len   = 8'($urandom_range(0, 7));
            fault = 0;
            if ($urandom_range(0, 3) == 0) fault = wr ? $urandom_range(1, 2) : $urandom_range(3, 5);
            run_txn(wr, 4'($urandom), 16'($urandom_range(0, 120) * 4), len, fault, 32'h0,
                    model_err(wr, fault, int'(len)), $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_cmd_master.md
Name: axi_cmd_master

Overview:
- AXI4 initiator: turns a simple command/stream interface into single-ID INCR bursts toward an AXI responder such as the on-chip AXI RAM.
- Serves as test-traffic source, NoC endpoint driver, and bring-up master for memory-mapped slaves.
- One transaction outstanding at a time; each transaction is either a write burst or a read burst.

Parameters:
ID_W_WIDTH, 4, write ID width; cmd_id width
ID_R_WIDTH, 4, read ID width; must be <= ID_W_WIDTH, reads use cmd_id[ID_R_WIDTH-1:0]
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 32, data bus width
BYTE_WIDTH, 8, strobe granularity; STRB_W = DATA_WIDTH/BYTE_WIDTH

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
cmd_valid / cmd_ready  in / out  1  command handshake
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_id  in  ID_W_WIDTH  transaction ID
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_len  in  8  AXI len (beats - 1)
wdata_in / wstrb_in  in  DATA_WIDTH / STRB_W  write payload stream
wdata_valid_in / wdata_ready_out  in / out  1  write stream handshake
rdata_out  out  DATA_WIDTH  read payload stream
rdata_valid / rdata_last / rdata_ready  out / out / in  1  read stream handshake; last beat flag
done_valid / done_write / done_err  out  1  one-cycle completion pulse, its type, error flag
aw_valid / aw_ready, ar_valid / ar_ready  out / in  1  address handshakes
aw_id / ar_id  out  ID_W_WIDTH / ID_R_WIDTH  address IDs
aw_addr / ar_addr  out  ADDR_WIDTH  address
aw_len / ar_len  out  8  burst length
aw_size / ar_size, aw_burst / ar_burst  out  3, 2  constant log2(STRB_W), 2'b01 (INCR)
w_valid / w_ready, w_last  out / in, out  1  write data handshake and last beat
w_data / w_strb  out  DATA_WIDTH / STRB_W  write data
b_valid / b_ready  in / out  1  write response handshake
b_id / b_resp  in  ID_W_WIDTH / 2  write response
r_valid / r_ready, r_last  in / out, in  1  read data handshake and last beat
r_id / r_data / r_resp  in  ID_R_WIDTH / DATA_WIDTH / 2  read data

Behaviour:
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- Reset (rst_n=0 at posedge): state IDLE; beat counter 0; error flag 0; aw_valid, ar_valid, done_valid, done_err, done_write all 0. cmd_ready = 1 only in IDLE.
- Reset mid-transaction: abort to IDLE on that edge; all valids drop; no done pulse.
- IDLE: cmd_valid & cmd_ready latches id, addr, len and write. Next state is WADDR if write, else RADDR. Address valid asserts the cycle after acceptance.
- WADDR / RADDR: aw_valid / ar_valid is registered. Address, id and len stay stable until the handshake. On aw_ready -> WDATA; on ar_ready -> RDATA.
- WDATA: combinational pass-through.
  - w_valid = wdata_valid_in; wdata_ready_out = w_ready.
  - w_data, w_strb = wdata_in, wstrb_in.
  - Counter increments per W handshake; w_last = (count == len).
  - Handshake on the last beat -> WRESP, counter cleared.
  - wdata_ready_out = 0 in every other state.
- WRESP: b_ready = 1. On b_valid -> DONE with err = (b_resp != 0) | (b_id != latched id).
- RDATA: combinational pass-through.
  - rdata_valid = r_valid; r_ready = rdata_ready; rdata_out = r_data; rdata_last = (count == len).
  - Err accumulates on any beat with r_resp != 0, r_id mismatch, or r_last != (count == len).
  - The transaction ends on the counted beat len regardless of r_last -> DONE.
  - r_ready = 0 outside RDATA.
- DONE: done_valid = 1 for exactly one cycle, with done_write and done_err valid. Then -> IDLE, with cmd_ready = 1 the next cycle.
- len = 0: single beat; w_last asserts on the first beat.
- Addresses are not checked for 4 KB crossing; the command source is responsible.

Test Plan:
- Write addr 0x0010, len 3, id 5, data 0xA0..0xA3, strb 0xF -> one AW (len 3, size 2, burst 1), 4 W beats, w_last only on 0xA3; b_resp 0 id 5 -> done_valid 1 cycle, done_write 1, done_err 0.
- Read addr 0x0010, len 3 after the write -> rdata 0xA0..0xA3, rdata_last on the 4th beat, done_err 0.
- rdata_ready and wdata_valid_in toggled randomly (50%) -> data order preserved, no lost or duplicated beats, counter exact.
- Responder returns b_resp 2'b10, or r_last on beat 1 of len 3 -> done_err 1; read still completes after 4 beats.
- len 0 write and read -> single beat with last set; cmd accept to aw_valid latency is 1 cycle.
- rst_n low during WDATA beat 2 -> next edge: all valids 0, cmd_ready 1, no done pulse; a following command completes normally.
